speed_sample_scheduler: RTL
===========================

Name: speed_sample_scheduler

Overview:
Time-shares one angle-difference datapath across N_CH encoder channels to produce per-channel rotation speed (angle delta per sample period). A programmable-period tick snapshots all channel angles coherently. An FSM then walks the channels, computes each delta and emits it on a valid/ready stream to the downstream speed controller. Sits between the encoder angle accumulators and the motor control loop.

Parameters:
N_CH, 4, number of encoder channels (>=1)
ANGLE_W, 32, angle and omega width (two's complement, modulo 2^ANGLE_W)
PERIOD, 1048576, sample period in clk cycles; must be >= 2*N_CH+2 (elaboration-time assertion)
SAT_LIMIT, 2**20, magnitude clamp, used only with SPEED_SAT_EN

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  run sample timer; low = timer held at 0
angle_flat  in  N_CH*ANGLE_W  channel k angle at bits [k*ANGLE_W +: ANGLE_W]
omega_data  out  ANGLE_W  signed delta for omega_ch
omega_ch  out  $clog2(N_CH) (min 1)  channel index of omega_data
omega_valid  out  1  output beat valid
omega_ready  in  1  downstream accepts beat
omega_sat  out  1  beat was clamped (0 without SPEED_SAT_EN)
busy  out  1  FSM not in IDLE
overrun  out  1  sticky: tick arrived while busy
overrun_clr  in  1  clears overrun

Behaviour:
- Reset values: all outputs 0, timer 0, FSM IDLE, ch 0, primed 0, snapshot/prev registers 0.
- Timer: counts 0..PERIOD-1 while enable=1; tick is the cycle with count==PERIOD-1; enable=0 clears and holds it at 0. An in-flight round always completes.
- FSM states: IDLE, CALC, EMIT.
- IDLE + tick, primed=0: prev[k] <= angle[k] for all k; primed <= 1; stay IDLE; nothing emitted.
- IDLE + tick, primed=1: snap[k] <= angle[k] for all k in the same edge (coherent); ch <= 0; -> CALC.
- CALC: omega_data <= snap[ch] - prev[ch] (modulo 2^ANGLE_W, wrap-around correct); prev[ch] <= snap[ch]; omega_ch <= ch; omega_valid <= 1; -> EMIT.
- EMIT: hold omega_data, omega_ch, omega_sat and omega_valid stable until omega_valid && omega_ready.
  - On accept with ch==N_CH-1: valid <= 0, -> IDLE.
  - On any other accept: ch++, valid <= 0, -> CALC.
- Latency: first valid asserts 2 cycles after the tick cycle. With ready held high, one beat every 2 cycles and the round lasts 2*N_CH cycles.
- Tick while busy: tick dropped; overrun <= 1; timer continues. overrun_clr and a set in the same cycle: set wins.
- Reset mid-round: valid is low in the following cycle; primed is cleared, so the first tick after reset only primes.
- busy = (state != IDLE).

Optional Feature:
SPEED_SAT_EN
- Defined: in CALC, a signed delta > SAT_LIMIT becomes SAT_LIMIT and a delta < -SAT_LIMIT becomes -SAT_LIMIT; omega_sat = 1 for that beat, else 0.
- Undefined: no clamp logic; omega_sat tied 0; SAT_LIMIT unused.

Decomposition:
- Package speed_pkg:
  - state enum (IDLE, CALC, EMIT)
  - ANGLE_W_DEFAULT
  - signed omega_t typedef
  - saturate function
- Sub-module period_tick_gen (parameter PERIOD): inputs clk, reset, enable; output tick.
- FSM, snapshot/prev arrays and output register stay in speed_sample_scheduler.

Test Plan:
1. N_CH=2, PERIOD=16, ready=1. Tick 1 with angles (100, 1000) -> no valid. Tick 2 with (150, 900) -> beats {ch0, 50} then {ch1, 0xFFFFFF9C}; first valid 2 cycles after the tick.
2. Wrap: ch0 prev 0xFFFFFFF0, next 0x00000010 -> omega_data 0x00000020.
3. Backpressure: ready low 5 cycles during a ch0 beat -> valid, data and ch held stable; ch1 is emitted only after acceptance.
4. Overrun: ready low > 16 cycles -> overrun=1 and the next tick is dropped (no extra round). Pulse overrun_clr -> 0. Overrun set and overrun_clr in the same cycle -> remains 1.
5. Reset asserted mid-EMIT -> valid 0 next cycle, busy 0. The next tick emits nothing (re-prime); the following tick emits normally.
6. SPEED_SAT_EN, SAT_LIMIT=1000: deltas +5000 and -5000 -> omega_data 1000 and -1000 (0xFFFFFC18), both with omega_sat=1. Delta 999 -> omega_sat=0.

Source files
------------

// File: rtl/speed_pkg.sv
// Shared types and helpers for the speed sample scheduler.
// The saturate helper is only referenced when SPEED_SAT_EN is defined.
package speed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int ANGLE_W_DEFAULT = 32;

    // Clamp arithmetic runs at a fixed wide width so any ANGLE_W up to 63 fits.
    localparam int WIDE_W = 64;

    typedef logic signed [ANGLE_W_DEFAULT-1:0] omega_t;

    typedef struct packed {
        logic                     sat;
        logic signed [WIDE_W-1:0] value;
    } sat_result_t;

    function automatic sat_result_t saturate(
        input logic signed [WIDE_W-1:0] value,
        input logic signed [WIDE_W-1:0] limit
    );
        sat_result_t r;
        r.sat   = 1'b0;
        r.value = value;
        if (value > limit) begin
            r.sat   = 1'b1;
            r.value = limit;
        end else if (value < -limit) begin
            r.sat   = 1'b1;
            r.value = -limit;
        end
        return r;
    endfunction

endpackage

// File: rtl/speed_sample_scheduler_period_tick_gen.sv
// Free-running sample-period timer: one-cycle tick every PERIOD cycles while enabled.
// Dropping enable clears the count so the next period starts fresh.
module period_tick_gen #(
    parameter int PERIOD = 1048576
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int                CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/speed_sample_scheduler.sv
// Time-shares one angle-difference datapath across N_CH channels and streams per-channel speed.
// Optional magnitude clamp on each delta when SPEED_SAT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a sample tick (first tick after reset only primes prev)
// CALC  | compute delta for channel ch into the output register
// EMIT  | hold beat until omega_ready, then advance channel or finish round
module speed_sample_scheduler
    import speed_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int ANGLE_W   = ANGLE_W_DEFAULT,
    parameter int PERIOD    = 1048576,
    parameter int SAT_LIMIT = 2**20,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH*ANGLE_W-1:0] angle_flat,
    output logic [ANGLE_W-1:0]      omega_data,
    output logic [CH_W-1:0]         omega_ch,
    output logic                    omega_valid,
    input  logic                    omega_ready,
    output logic                    omega_sat,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    if (N_CH < 1) begin : g_nch_check
        $error("N_CH must be at least 1");
    end
    if (PERIOD < 2*N_CH + 2) begin : g_period_check
        $error("PERIOD must be at least 2*N_CH+2 so a round finishes before the next tick");
    end
    if (SAT_LIMIT < 1) begin : g_sat_check
        $error("SAT_LIMIT must be positive");
    end

    state_t             state_q, state_d;
    logic [CH_W-1:0]    ch_q;
    logic               primed_q;
    logic [ANGLE_W-1:0] snap_q  [N_CH];
    logic [ANGLE_W-1:0] prev_q  [N_CH];
    logic [ANGLE_W-1:0] angle_k [N_CH];

    logic               tick;
    logic               do_prime;
    logic               do_snap;
    logic               do_calc;
    logic               do_accept;
    logic               last_ch;
    logic [ANGLE_W-1:0] delta;
    logic [ANGLE_W-1:0] omega_d;
    logic               sat_d;

    period_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            angle_k[k] = angle_flat[k*ANGLE_W +: ANGLE_W];
        end
    end

    assign last_ch = (ch_q == CH_W'(N_CH - 1));
    assign delta   = snap_q[ch_q] - prev_q[ch_q];

`ifdef SPEED_SAT_EN
    sat_result_t sat_res;

    assign sat_res = saturate(WIDE_W'(signed'(delta)), WIDE_W'(SAT_LIMIT));
    assign omega_d = sat_res.value[ANGLE_W-1:0];
    assign sat_d   = sat_res.sat;
`else
    assign omega_d = delta;
    assign sat_d   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        do_prime  = 1'b0;
        do_snap   = 1'b0;
        do_calc   = 1'b0;
        do_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    if (primed_q) begin
                        do_snap = 1'b1;
                        state_d = CALC;
                    end else begin
                        do_prime = 1'b1;
                    end
                end
            end
            CALC: begin
                do_calc = 1'b1;
                state_d = EMIT;
            end
            EMIT: begin
                if (omega_valid && omega_ready) begin
                    do_accept = 1'b1;
                    state_d   = last_ch ? IDLE : CALC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A tick that lands mid-round is dropped; only the sticky flag records it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q        <= '0;
            primed_q    <= 1'b0;
            omega_data  <= '0;
            omega_ch    <= '0;
            omega_valid <= 1'b0;
            omega_sat   <= 1'b0;
            overrun     <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                snap_q[k] <= '0;
                prev_q[k] <= '0;
            end
        end else begin
            if (do_prime) begin
                primed_q <= 1'b1;
                for (int k = 0; k < N_CH; k++) begin
                    prev_q[k] <= angle_k[k];
                end
            end
            if (do_snap) begin
                ch_q <= '0;
                for (int k = 0; k < N_CH; k++) begin
                    snap_q[k] <= angle_k[k];
                end
            end
            if (do_calc) begin
                omega_data   <= omega_d;
                omega_sat    <= sat_d;
                omega_ch     <= ch_q;
                omega_valid  <= 1'b1;
                prev_q[ch_q] <= snap_q[ch_q];
            end
            if (do_accept) begin
                omega_valid <= 1'b0;
                if (!last_ch) begin
                    ch_q <= ch_q + CH_W'(1);
                end
            end
            if (tick && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule
